// File: rtl/cache_data_array.sv
// Set-associative cache data store: byte-masked single-way writes,
// all-way parallel reads with 0- or 1-cycle latency and write forwarding.
module cache_data_array #(
  parameter int BLOCK_BITS   = 256,
  parameter int NUM_SETS     = 8,
  parameter int NUM_WAYS     = 2,
  parameter int READ_LATENCY = 1,
  localparam int SET_W  = (NUM_SETS > 1) ? $clog2(NUM_SETS) : 1,
  localparam int WAY_W  = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1,
  localparam int NBYTES = BLOCK_BITS / 8
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           rd_en,
  input  logic [SET_W-1:0]               rd_set,
  input  logic                           wr_en,
  input  logic [SET_W-1:0]               wr_set,
  input  logic [WAY_W-1:0]               wr_way,
  input  logic [NBYTES-1:0]              wr_byte_en,
  input  logic [BLOCK_BITS-1:0]          din,
  output logic [NUM_WAYS*BLOCK_BITS-1:0] dout,
  output logic                           rd_valid
);

  localparam int NLINES = NUM_SETS * NUM_WAYS;
  localparam int IDX_W  = (NLINES > 1) ? $clog2(NLINES) : 1;

  logic [BLOCK_BITS-1:0] mem_q [NLINES];
  logic [BLOCK_BITS-1:0] mem_d [NLINES];

  logic                          wr_ok;
  logic [IDX_W-1:0]              wr_idx;
  logic [NUM_WAYS*BLOCK_BITS-1:0] view;

  function automatic logic [BLOCK_BITS-1:0] merge_bytes(
    input logic [BLOCK_BITS-1:0] old_line,
    input logic [BLOCK_BITS-1:0] new_line,
    input logic [NBYTES-1:0]     be
  );
    logic [BLOCK_BITS-1:0] r;
    r = old_line;
    for (int b = 0; b < NBYTES; b++) begin
      if (be[b]) r[b*8 +: 8] = new_line[b*8 +: 8];
    end
    return r;
  endfunction

  function automatic logic [IDX_W-1:0] line_idx(
    input logic [SET_W-1:0] s,
    input int               w
  );
    return IDX_W'(int'(s) * NUM_WAYS + w);
  endfunction

  always_comb begin
    wr_ok  = wr_en
           && (int'(wr_set) < NUM_SETS)
           && (int'(wr_way) < NUM_WAYS);
    wr_idx = line_idx(wr_set, int'(wr_way));
    mem_d  = mem_q;
    if (wr_ok) begin
      mem_d[wr_idx] = merge_bytes(mem_q[wr_idx], din, wr_byte_en);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NLINES; i++) mem_q[i] <= '0;
    end else begin
      mem_q <= mem_d;
    end
  end

  // Write-first view: the way being written shows the new bytes now
  always_comb begin
    view = '0;
    for (int w = 0; w < NUM_WAYS; w++) begin
      if (int'(rd_set) < NUM_SETS) begin
        view[w*BLOCK_BITS +: BLOCK_BITS] = mem_q[line_idx(rd_set, w)];
        if (wr_en && (wr_set == rd_set) && (int'(wr_way) == w)) begin
          view[w*BLOCK_BITS +: BLOCK_BITS] =
            merge_bytes(view[w*BLOCK_BITS +: BLOCK_BITS],
                        din, wr_byte_en);
        end
      end
    end
  end

  if (READ_LATENCY == 0) begin : g_comb
    assign dout     = rst ? '0 : view;
    assign rd_valid = rd_en & ~rst;
  end else if (READ_LATENCY == 1) begin : g_reg
    logic [NUM_WAYS*BLOCK_BITS-1:0] dout_q;
    logic [NUM_WAYS*BLOCK_BITS-1:0] dout_d;
    logic                           rd_valid_q;
    logic                           rd_valid_d;

    always_comb begin
      dout_d     = rd_en ? view : dout_q;
      rd_valid_d = rd_en;
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        dout_q     <= '0;
        rd_valid_q <= 1'b0;
      end else begin
        dout_q     <= dout_d;
        rd_valid_q <= rd_valid_d;
      end
    end

    assign dout     = dout_q;
    assign rd_valid = rd_valid_q;
  end else begin : g_bad_latency
    $error("cache_data_array: READ_LATENCY must be 0 or 1");
  end

endmodule

// File: tb/tb_cache_data_array.sv
// Bench: registered 8-set DUT and combinational 6-set DUT on shared
// stimulus, checked against an array model plus directed constants.
module tb_cache_data_array;

  logic         clk;
  logic         rst;
  logic         rd_en;
  logic [2:0]   rd_set;
  logic         wr_en;
  logic [2:0]   wr_set;
  logic         wr_way;
  logic [31:0]  wr_byte_en;
  logic [255:0] din;
  logic [511:0] dout_a;
  logic [511:0] dout_b;
  logic         rd_valid_a;
  logic         rd_valid_b;

  int total = 0;
  int bad   = 0;

  logic [255:0] ma [8][2];
  logic [255:0] mb [6][2];
  logic [511:0] exp_a;
  logic         exp_va;

  typedef struct {
    logic         rst;
    logic         rd_en;
    logic [2:0]   rd_set;
    logic         wr_en;
    logic [2:0]   wr_set;
    logic         wr_way;
    logic [31:0]  be;
    logic [255:0] din;
    logic         chk;
    logic         vld;
    logic [31:0]  w0;
    logic [31:0]  w1;
  } vec_t;

  vec_t tbl[$];

  cache_data_array #(
    .BLOCK_BITS(256), .NUM_SETS(8), .NUM_WAYS(2), .READ_LATENCY(1)
  ) u_a (
    .clk(clk), .rst(rst), .rd_en(rd_en), .rd_set(rd_set),
    .wr_en(wr_en), .wr_set(wr_set), .wr_way(wr_way),
    .wr_byte_en(wr_byte_en), .din(din),
    .dout(dout_a), .rd_valid(rd_valid_a)
  );

  cache_data_array #(
    .BLOCK_BITS(256), .NUM_SETS(6), .NUM_WAYS(2), .READ_LATENCY(0)
  ) u_b (
    .clk(clk), .rst(rst), .rd_en(rd_en), .rd_set(rd_set),
    .wr_en(wr_en), .wr_set(wr_set), .wr_way(wr_way),
    .wr_byte_en(wr_byte_en), .din(din),
    .dout(dout_b), .rd_valid(rd_valid_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(
    input logic rs, input logic re, input int rs_set,
    input logic we, input int ws, input int ww,
    input logic [31:0] be, input logic [255:0] d,
    input logic c, input logic v,
    input logic [31:0] w0, input logic [31:0] w1
  );
    vec_t r;
    r.rst = rs; r.rd_en = re; r.rd_set = 3'(rs_set);
    r.wr_en = we; r.wr_set = 3'(ws); r.wr_way = 1'(ww);
    r.be = be; r.din = d;
    r.chk = c; r.vld = v; r.w0 = w0; r.w1 = w1;
    return r;
  endfunction

  function automatic logic [255:0] mrg(
    input logic [255:0] o, input logic [255:0] n, input logic [31:0] be
  );
    logic [255:0] r;
    r = o;
    for (int b = 0; b < 32; b++) if (be[b]) r[b*8 +: 8] = n[b*8 +: 8];
    return r;
  endfunction

  function automatic logic [511:0] view(input bit isb);
    logic [511:0] r;
    logic [255:0] line;
    int ns;
    r  = '0;
    ns = isb ? 6 : 8;
    if (int'(rd_set) < ns) begin
      for (int w = 0; w < 2; w++) begin
        line = isb ? mb[rd_set][w] : ma[rd_set][w];
        if (wr_en && wr_set == rd_set && int'(wr_way) == w)
          line = mrg(line, din, wr_byte_en);
        r[w*256 +: 256] = line;
      end
    end
    return r;
  endfunction

  task automatic chk(input string nm, input logic [511:0] act,
                     input logic [511:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic step(input vec_t v);
    logic [511:0] nxt;
    @(negedge clk);
    rst = v.rst; rd_en = v.rd_en; rd_set = v.rd_set;
    wr_en = v.wr_en; wr_set = v.wr_set; wr_way = v.wr_way;
    wr_byte_en = v.be; din = v.din;
    #1;
    chk("b_dout", dout_b, v.rst ? '0 : view(1));
    chk("b_valid", {511'b0, rd_valid_b}, {511'b0, v.rd_en & ~v.rst});
    nxt = view(0);
    @(posedge clk);
    #1;
    if (v.rst) begin
      exp_a  = '0;
      exp_va = 1'b0;
      for (int s = 0; s < 8; s++)
        for (int w = 0; w < 2; w++) ma[s][w] = '0;
      for (int s = 0; s < 6; s++)
        for (int w = 0; w < 2; w++) mb[s][w] = '0;
    end else begin
      if (v.rd_en) exp_a = nxt;
      exp_va = v.rd_en;
      if (v.wr_en) begin
        ma[v.wr_set][v.wr_way] = mrg(ma[v.wr_set][v.wr_way], v.din, v.be);
        if (v.wr_set < 3'd6)
          mb[v.wr_set][v.wr_way] =
            mrg(mb[v.wr_set][v.wr_way], v.din, v.be);
      end
    end
    chk("a_dout", dout_a, exp_a);
    chk("a_valid", {511'b0, rd_valid_a}, {511'b0, exp_va});
    if (v.chk) begin
      chk("k_valid", {511'b0, rd_valid_a}, {511'b0, v.vld});
      chk("k_way0", {480'b0, dout_a[31:0]}, {480'b0, v.w0});
      chk("k_way1", {480'b0, dout_a[287:256]}, {480'b0, v.w1});
    end
  endtask

  initial begin
    logic [255:0] a5, c3, ff, pat, rnd;
    logic [7:0]   pb;
    logic [31:0]  be;
    vec_t         v;

    rst = 1'b1; rd_en = 1'b0; rd_set = '0; wr_en = 1'b0;
    wr_set = '0; wr_way = 1'b0; wr_byte_en = '0; din = '0;
    exp_a = '0; exp_va = 1'b0;
    for (int s = 0; s < 8; s++)
      for (int w = 0; w < 2; w++) ma[s][w] = '0;
    for (int s = 0; s < 6; s++)
      for (int w = 0; w < 2; w++) mb[s][w] = '0;

    a5 = {32{8'hA5}};
    c3 = {32{8'h3C}};
    ff = '1;
    tbl.push_back(mk(1,0,0, 0,0,0, 0, 0, 1,0, 0, 0));
    tbl.push_back(mk(0,1,3, 0,0,0, 0, 0, 1,1, 0, 0));
    tbl.push_back(mk(0,0,0, 0,0,0, 0, 0, 1,0, 0, 0));
    tbl.push_back(mk(0,0,0, 1,5,1, '1, a5, 1,0, 0, 0));
    tbl.push_back(mk(0,0,0, 1,5,1, 32'hF, c3, 1,0, 0, 0));
    tbl.push_back(mk(0,1,5, 0,0,0, 0, 0, 1,1, 0, 32'h3C3C3C3C));
    tbl.push_back(mk(0,1,2, 1,2,0, 32'hF, 256'hDEADBEEF,
                     1,1, 32'hDEADBEEF, 0));
    tbl.push_back(mk(0,1,4, 1,2,0, 32'hF, 256'h11223344, 1,1, 0, 0));
    tbl.push_back(mk(0,1,2, 0,0,0, 0, 0, 1,1, 32'h11223344, 0));
    tbl.push_back(mk(0,1,6, 1,7,0, '1, ff, 1,1, 0, 0));
    tbl.push_back(mk(0,1,7, 0,0,0, 0, 0, 1,1, 32'hFFFFFFFF, 0));
    tbl.push_back(mk(0,0,0, 1,1,1, 0, ff, 1,0, 32'hFFFFFFFF, 0));
    tbl.push_back(mk(0,1,1, 0,0,0, 0, 0, 1,1, 0, 0));
    for (int i = 0; i < tbl.size(); i++) step(tbl[i]);

    for (int s = 0; s < 8; s++) begin
      for (int w = 0; w < 2; w++) begin
        pb  = 8'(s * 16 + w);
        pat = {32{pb}};
        step(mk(0,0,0, 1,s,w, '1, pat, 0,0, 0, 0));
      end
    end
    step(mk(0,1,1, 0,0,0, 0, 0, 1,1, 32'h10101010, 32'h11111111));
    step(mk(0,1,7, 0,0,0, 0, 0, 1,1, 32'h70707070, 32'h71717171));
    step(mk(1,1,3, 1,3,0, '1, ff, 1,0, 0, 0));
    for (int s = 0; s < 8; s++) step(mk(0,1,s, 0,0,0, 0, 0, 1,1, 0, 0));

    for (int i = 0; i < 400; i++) begin
      for (int k = 0; k < 8; k++) rnd[k*32 +: 32] = $urandom;
      case ($urandom_range(0, 3))
        0:       be = '0;
        1:       be = '1;
        default: be = $urandom;
      endcase
      v = mk($urandom_range(0, 39) == 0, 1'($urandom),
             $urandom_range(0, 7), 1'($urandom),
             $urandom_range(0, 7), $urandom_range(0, 1),
             be, rnd, 0, 0, 0, 0);
      step(v);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cache_data_array.md
Name: cache_data_array

Overview:
Parametrised set-associative cache data store that replaces the single-way, fixed-depth data array.
- Holds NUM_SETS x NUM_WAYS lines of BLOCK_BITS each.
- Supports byte-masked writes into one way per cycle.
- A read returns all ways of one set in parallel; hit-way selection is done downstream.
- Selectable 0- or 1-cycle read latency, with same-cycle write forwarding, so it serves both the combinational L1 path and a registered L2 path.

Parameters:
BLOCK_BITS, 256, line width in bits; must be a multiple of 8.
NUM_SETS, 8, number of sets; any value >= 1.
NUM_WAYS, 2, associativity; any value >= 1.
READ_LATENCY, 1, 0 = combinational read, 1 = registered read; other values are illegal (elaboration error).
Derived: SET_W = max(1, clog2(NUM_SETS)), WAY_W = max(1, clog2(NUM_WAYS)), NBYTES = BLOCK_BITS/8.

Ports:
clk  in  1  clock
rst  in  1  reset
rd_en  in  1  read request
rd_set  in  SET_W  set index to read
wr_en  in  1  write request
wr_set  in  SET_W  set index to write
wr_way  in  WAY_W  way to write
wr_byte_en  in  NBYTES  per-byte write mask; bit i covers din[8i+7:8i]
din  in  BLOCK_BITS  write data
dout  out  NUM_WAYS*BLOCK_BITS  way w occupies bits [w*BLOCK_BITS +: BLOCK_BITS]
rd_valid  out  1  dout holds data for an accepted read

Behaviour:
- Reset: rst is synchronous, active-high; clock is clk.
  - While rst is high, every line of every way is cleared to 0, dout = 0 and rd_valid = 0.
  - rst has priority over simultaneous rd_en/wr_en; those requests are dropped.
  - Reset mid-read (latency 1) discards the pending read; rd_valid is 0 on the following cycle.
- Write:
  - On a clk edge with wr_en=1, rst=0, wr_set < NUM_SETS and wr_way < NUM_WAYS, each byte i of line [wr_set][wr_way] with wr_byte_en[i]=1 takes din byte i.
  - Unmasked bytes are unchanged.
  - wr_byte_en = 0 is a legal no-op.
  - Writes with an out-of-range set or way index are ignored with no state change.
- Read data (merged view): for each way w, the line at [rd_set][w] as stored, except that if wr_en=1 this cycle with wr_set == rd_set and wr_way == w, bytes enabled in wr_byte_en come from din.
  - This gives write-first semantics.
  - A read with out-of-range rd_set returns 0 for all ways.
- READ_LATENCY=0:
  - dout = merged view of rd_set, combinationally, regardless of rd_en.
  - rd_valid = rd_en & ~rst, combinational.
- READ_LATENCY=1:
  - On a clk edge with rd_en=1, dout is loaded with the merged view of rd_set from that cycle, and rd_valid <= 1.
  - With rd_en=0, dout holds its last value and rd_valid <= 0.
  - A write landing on a set/way already captured does not alter the held dout.
  - Back-to-back reads are supported, one per cycle, with full throughput.
- Simultaneous read and write to different sets are independent.
- Same set, different way: only the written way is merged; other ways show stored data.
- Storage is one flat array of NUM_SETS*NUM_WAYS lines; there are no X values after reset.

Test Plan:
1. Reset, then with READ_LATENCY=1 read set 3 -> one cycle later dout = 0 and rd_valid = 1; the next cycle with rd_en=0 gives rd_valid = 0 and dout held.
2. Write set 5 way 1 with din = {32{8'hA5}} and wr_byte_en = all 1s, then a later write of din = {32{8'h3C}} with wr_byte_en = 32'h0000_000F; read set 5 -> way 1 has low 4 bytes = 3C and the rest A5; way 0 = 0.
3. Same cycle: write set 2 way 0 with 0xDEAD_BEEF in byte lanes 3:0 and read set 2 -> dout way 0 low word = DEADBEEF, in the same cycle (latency 0) or the next cycle (latency 1).
4. Same cycle: write set 2 way 0 and read set 4 -> set 4 data is returned unmerged; a subsequent read of set 2 shows the write.
5. With NUM_SETS=6, write wr_set=7 -> no line changes; read rd_set=6 -> dout = 0.
6. Fill all 16 lines with unique patterns (set*16+way in every byte), assert rst for one cycle mid-stream while rd_en=1, then read every set -> all 0 and rd_valid = 0 on the cycle after rst.
